// File: rtl/wbm.sv
// Write-back stage: owns the 32x32 integer register file, commits execute-stage
// results, services debug writes and counts retired instructions. A one-entry
// holding buffer keeps a pipeline result that collides with a debug write.
module wbm #(
    parameter int RETIRED_WIDTH = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     input_valid_i,
    output logic                     input_ready_o,
    input  logic                     result_write_i,
    input  logic [4:0]               result_addr_i,
    input  logic [31:0]              result_i,
    input  logic                     dbg_write_i,
    input  logic [4:0]               dbg_addr_i,
    input  logic [31:0]              dbg_data_i,
    input  logic [4:0]               rs1_addr_i,
    input  logic [4:0]               rs2_addr_i,
    output logic [31:0]              rs1_data_o,
    output logic [31:0]              rs2_data_o,
    output logic [RETIRED_WIDTH-1:0] retired_o
);

    logic [31:0]              regFile_q [32];
    logic                     bufValid_q, bufValid_d;
    logic [4:0]               bufAddr_q, bufAddr_d;
    logic [31:0]              bufData_q, bufData_d;
    logic [RETIRED_WIDTH-1:0] retired_q, retired_d;

    logic                     accept;
    logic                     pipeWrite;
    logic                     wrEn;
    logic [4:0]               wrAddr;
    logic [31:0]              wrData;

    assign input_ready_o = ~rst_i & ~bufValid_q;
    assign accept        = input_valid_i & input_ready_o;
    assign pipeWrite     = accept & result_write_i & (result_addr_i != 5'd0);
    assign retired_o     = retired_q;

    // Single array write port: debug first, then draining buffer, then pipeline.
    always_comb begin
        wrEn   = 1'b0;
        wrAddr = 5'd0;
        wrData = 32'd0;
        if (dbg_write_i) begin
            wrEn   = (dbg_addr_i != 5'd0);
            wrAddr = dbg_addr_i;
            wrData = dbg_data_i;
        end else if (bufValid_q) begin
            wrEn   = 1'b1;
            wrAddr = bufAddr_q;
            wrData = bufData_q;
        end else if (pipeWrite) begin
            wrEn   = 1'b1;
            wrAddr = result_addr_i;
            wrData = result_i;
        end
        if (rst_i) begin
            wrEn = 1'b0;
        end
    end

    // Holding buffer captures a colliding result and drains once debug goes quiet.
    always_comb begin
        bufValid_d = bufValid_q;
        bufAddr_d  = bufAddr_q;
        bufData_d  = bufData_q;
        if (dbg_write_i && pipeWrite) begin
            bufValid_d = 1'b1;
            bufAddr_d  = result_addr_i;
            bufData_d  = result_i;
        end else if (!dbg_write_i && bufValid_q) begin
            bufValid_d = 1'b0;
        end
    end

    // Retired counter advances on every accepted transfer and wraps naturally.
    always_comb begin
        retired_d = retired_q;
        if (accept) begin
            retired_d = retired_q + RETIRED_WIDTH'(1);
        end
    end

    // Read port 1: buffered entry beats the in-flight write, which beats the array.
    always_comb begin
        rs1_data_o = regFile_q[rs1_addr_i];
        if (wrEn && (wrAddr == rs1_addr_i)) begin
            rs1_data_o = wrData;
        end
        if (bufValid_q && (bufAddr_q == rs1_addr_i)) begin
            rs1_data_o = bufData_q;
        end
        if (rs1_addr_i == 5'd0) begin
            rs1_data_o = 32'd0;
        end
    end

    // Read port 2: same bypass priority as port 1.
    always_comb begin
        rs2_data_o = regFile_q[rs2_addr_i];
        if (wrEn && (wrAddr == rs2_addr_i)) begin
            rs2_data_o = wrData;
        end
        if (bufValid_q && (bufAddr_q == rs2_addr_i)) begin
            rs2_data_o = bufData_q;
        end
        if (rs2_addr_i == 5'd0) begin
            rs2_data_o = 32'd0;
        end
    end

    // Buffer and counter state; reset throws away any pending buffered result.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bufValid_q <= 1'b0;
            bufAddr_q  <= 5'd0;
            bufData_q  <= 32'd0;
            retired_q  <= '0;
        end else begin
            bufValid_q <= bufValid_d;
            bufAddr_q  <= bufAddr_d;
            bufData_q  <= bufData_d;
            retired_q  <= retired_d;
        end
    end

    // Register file array; x0 is never written so it stays zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 32; i++) begin
                regFile_q[i] <= 32'd0;
            end
        end else if (wrEn) begin
            regFile_q[wrAddr] <= wrData;
        end
    end

endmodule

// File: tb/tb_wbm.sv
// Directed testbench for the write-back stage, using a 4-bit retired counter
// so that wrap-around is reachable with a short transfer sequence.
module tb_wbm;

   localparam int RW = 4;

   logic          clk_i;
   logic          rst_i;
   logic          input_valid_i;
   logic          input_ready_o;
   logic          result_write_i;
   logic [4:0]    result_addr_i;
   logic [31:0]   result_i;
   logic          dbg_write_i;
   logic [4:0]    dbg_addr_i;
   logic [31:0]   dbg_data_i;
   logic [4:0]    rs1_addr_i;
   logic [4:0]    rs2_addr_i;
   logic [31:0]   rs1_data_o;
   logic [31:0]   rs2_data_o;
   logic [RW-1:0] retired_o;

   int checkCount;
   int errorCount;

   wbm #(.RETIRED_WIDTH(RW)) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .input_valid_i  (input_valid_i),
      .input_ready_o  (input_ready_o),
      .result_write_i (result_write_i),
      .result_addr_i  (result_addr_i),
      .result_i       (result_i),
      .dbg_write_i    (dbg_write_i),
      .dbg_addr_i     (dbg_addr_i),
      .dbg_data_i     (dbg_data_i),
      .rs1_addr_i     (rs1_addr_i),
      .rs2_addr_i     (rs2_addr_i),
      .rs1_data_o     (rs1_data_o),
      .rs2_data_o     (rs2_data_o),
      .retired_o      (retired_o)
   );

   // Free-running 10 ns clock.
   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   // Compare one observed value against its expected value and tally the result.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCount++;
      if (got !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Drive the execute-stage and debug inputs for the coming cycle.
   task automatic applyStimulus(input logic valid, input logic wr, input logic [4:0] addr,
                                input logic [31:0] data, input logic dbgWr,
                                input logic [4:0] dbgAddr, input logic [31:0] dbgData);
      input_valid_i  = valid;
      result_write_i = wr;
      result_addr_i  = addr;
      result_i       = data;
      dbg_write_i    = dbgWr;
      dbg_addr_i     = dbgAddr;
      dbg_data_i     = dbgData;
   endtask

   // Advance one clock edge and settle just after it.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Hand-computed expected retired count, kept modulo 16 at each use.
   int expRetired;

   initial begin
      checkCount = 0;
      errorCount = 0;
      expRetired = 0;
      rst_i      = 1'b1;
      rs1_addr_i = 5'd0;
      rs2_addr_i = 5'd0;
      applyStimulus(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);

      // Reset state
      tick();
      checkOutput("rst_ready", {31'd0, input_ready_o}, 32'd0);
      checkOutput("rst_retired", {28'd0, retired_o}, 32'd0);
      @(negedge clk_i);
      rst_i = 1'b0;
      tick();
      checkOutput("post_rst_ready", {31'd0, input_ready_o}, 32'd1);

      // Basic write with same-cycle bypass
      applyStimulus(1, 1, 5'd3, 32'hDEADBEEF, 0, 5'd0, 32'd0);
      rs1_addr_i = 5'd3;
      #1;
      checkOutput("bypass_rs1", rs1_data_o, 32'hDEADBEEF);
      tick();
      applyStimulus(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
      #1;
      expRetired = 1;
      checkOutput("array_rs1", rs1_data_o, 32'hDEADBEEF);
      checkOutput("retired_1", {28'd0, retired_o}, expRetired);

      // x0 protection from both sources
      applyStimulus(1, 1, 5'd0, 32'h1234, 1, 5'd0, 32'hFFFF);
      rs2_addr_i = 5'd0;
      #1;
      checkOutput("x0_same_cycle", rs2_data_o, 32'd0);
      tick();
      applyStimulus(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
      #1;
      expRetired = 2;
      checkOutput("x0_after", rs2_data_o, 32'd0);
      checkOutput("x0_ready", {31'd0, input_ready_o}, 32'd1);
      checkOutput("x0_retired", {28'd0, retired_o}, expRetired);

      // Collision on the same address: pipeline value ends up in the array
      applyStimulus(1, 1, 5'd7, 32'h5555, 1, 5'd7, 32'hAAAA);
      rs1_addr_i = 5'd7;
      rs2_addr_i = 5'd7;
      tick();
      applyStimulus(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
      #1;
      expRetired = 3;
      checkOutput("coll_ready", {31'd0, input_ready_o}, 32'd0);
      checkOutput("coll_buf_rs1", rs1_data_o, 32'h5555);
      checkOutput("coll_retired", {28'd0, retired_o}, expRetired);
      tick();
      checkOutput("coll_drain_ready", {31'd0, input_ready_o}, 32'd1);
      checkOutput("coll_array_rs2", rs2_data_o, 32'h5555);

      // Held debug write keeps the buffer for three cycles
      applyStimulus(1, 1, 5'd9, 32'h1111, 1, 5'd10, 32'h2222);
      rs1_addr_i = 5'd9;
      rs2_addr_i = 5'd10;
      tick();
      expRetired = 4;
      applyStimulus(1, 1, 5'd11, 32'h4444, 1, 5'd10, 32'h3333);
      for (int c = 0; c < 3; c++) begin
         #1;
         checkOutput($sformatf("hold_ready_%0d", c), {31'd0, input_ready_o}, 32'd0);
         checkOutput($sformatf("hold_buf_%0d", c), rs1_data_o, 32'h1111);
         checkOutput($sformatf("hold_retired_%0d", c), {28'd0, retired_o}, expRetired);
         if (c == 2) begin
            dbg_write_i = 1'b0;
         end
         tick();
      end
      checkOutput("drain_ready", {31'd0, input_ready_o}, 32'd1);
      checkOutput("drain_rs1", rs1_data_o, 32'h1111);
      checkOutput("drain_dbg_rs2", rs2_data_o, 32'h3333);
      checkOutput("drain_retired", {28'd0, retired_o}, expRetired);
      tick();
      applyStimulus(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
      rs1_addr_i = 5'd11;
      #1;
      expRetired = 5;
      checkOutput("held_accept_retired", {28'd0, retired_o}, expRetired);
      checkOutput("held_accept_rs1", rs1_data_o, 32'h4444);

      // Asynchronous reset mid-cycle with the buffer occupied
      applyStimulus(1, 1, 5'd12, 32'h7777, 1, 5'd13, 32'h8888);
      tick();
      applyStimulus(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
      #1;
      checkOutput("pre_rst_ready", {31'd0, input_ready_o}, 32'd0);
      #1;
      rst_i      = 1'b1;
      rs1_addr_i = 5'd5;
      rs2_addr_i = 5'd3;
      #1;
      checkOutput("async_retired", {28'd0, retired_o}, 32'd0);
      checkOutput("async_ready", {31'd0, input_ready_o}, 32'd0);
      checkOutput("async_rs1", rs1_data_o, 32'd0);
      checkOutput("async_rs2", rs2_data_o, 32'd0);
      @(negedge clk_i);
      rst_i = 1'b0;
      rs1_addr_i = 5'd12;
      tick();
      checkOutput("release_ready", {31'd0, input_ready_o}, 32'd1);
      checkOutput("buf_discarded", rs1_data_o, 32'd0);

      // Back-to-back transfers through counter wrap
      expRetired = 0;
      for (int i = 1; i <= 17; i++) begin
         applyStimulus(1, i[0], i[4:0], i * 32'h01010101, 0, 5'd0, 32'd0);
         #1;
         checkOutput($sformatf("b2b_ready_%0d", i), {31'd0, input_ready_o}, 32'd1);
         tick();
         expRetired = i % 16;
         checkOutput($sformatf("b2b_retired_%0d", i), {28'd0, retired_o}, expRetired);
      end
      applyStimulus(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
      rs1_addr_i = 5'd17;
      rs2_addr_i = 5'd16;
      #1;
      checkOutput("wrap_retired", {28'd0, retired_o}, 32'd1);
      checkOutput("wrap_rs1_written", rs1_data_o, 32'h11111111);
      checkOutput("wrap_rs2_nowrite", rs2_data_o, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/wbm.md
# wbm

Write-back stage of the ECAP5-DPROC pipeline. It consumes the result stream from the execute stage over a valid/ready handshake and commits results into the 32×32-bit integer register file, which it owns. It exposes two read ports to decode and a debug write port. It also maintains a retired-instruction counter. A one-entry holding buffer absorbs collisions between pipeline writes and debug writes, so no result is ever dropped.

## Interface
Parameters:
- RETIRED_WIDTH, 64, width of the retired-instruction counter

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- input_valid_i  in  1  execute stage presents a result
- input_ready_o  out  1  wbm can accept a result this cycle
- result_write_i  in  1  result must be written to the register file
- result_addr_i  in  5  destination register index
- result_i  in  32  result value
- dbg_write_i  in  1  debug write request, single cycle, always serviced
- dbg_addr_i  in  5  debug destination register
- dbg_data_i  in  32  debug write value
- rs1_addr_i, rs2_addr_i  in  5  read-port addresses from decode
- rs1_data_o, rs2_data_o  out  32  read-port data, combinational
- retired_o  out  RETIRED_WIDTH  count of accepted transfers

## Operation
- Transfer: a transfer is accepted on a rising edge where input_valid_i and input_ready_o are both high.
- Ready: input_ready_o = ~rst_i & ~buf_valid.
- Register x0: x0 is hardwired to 0.
  - Writes to address 0 from any source are discarded and never buffered.
  - Reads of address 0 return 0.
- Write-port arbitration: one array write per cycle, in this priority order:
  1. dbg_write_i writes dbg_data_i to dbg_addr_i.
  2. Otherwise, if buf_valid, the buffer entry is written and buf_valid clears.
  3. Otherwise, an accepted transfer with result_write_i=1 and result_addr_i≠0 writes directly.
- Collision: an accepted transfer with result_write_i=1 and result_addr_i≠0 in the same cycle as dbg_write_i is stored in the buffer, and buf_valid is set.
- Buffer persistence: while dbg_write_i stays high, the buffer entry is held.
- Same-address debug write: the pipeline value drains after the debug write, so the pipeline value is the final register content.
- Accepted transfers with result_write_i=0 update only the counter.
- Read bypass: each read port returns, in this priority:
  1. The buffered data, if buf_valid and the address matches.
  2. Otherwise, the data being written this cycle, if the address matches.
  3. Otherwise, the array contents.
  4. 0 for address 0, in all cases.
- Retired counter: retired_o increments by 1 on every accepted transfer and wraps from 2^RETIRED_WIDTH−1 to 0.

## Timing
- Reset (asynchronous, immediate):
  - All registers are 0, buf_valid=0, retired_o=0.
  - input_ready_o=0 while rst_i is high, then 1 in the first cycle after release.
  - rs1_data_o and rs2_data_o are 0 for every address.
- Reset mid-operation: an asserted rst_i discards the buffer entry and any transfer presented in that cycle.
- Write latency: the array is updated at the accepting edge. A read in the same cycle sees the value through the bypass; later cycles read it from the array.
- Buffer latency: a buffered result is written on the first edge with dbg_write_i=0 after capture.
- input_ready_o is low for every cycle buf_valid=1. Minimum bubble is one cycle, the drain cycle.
- The upstream stage must hold input_valid_i and its data stable while input_ready_o=0. wbm does not sample them in those cycles.
- Back-to-back: with no debug activity, one transfer is accepted per cycle indefinitely.
- The counter updates on the accepting edge. retired_o is registered.

## Test plan
- Reset: assert rst_i asynchronously mid-cycle with buf_valid=1.
  - Immediately: retired_o=0, input_ready_o=0, rs1_data_o=0 for rs1_addr_i=5.
  - After release: input_ready_o=1.
- Basic write and bypass: accept {write=1, addr=3, data=0xDEADBEEF} with rs1_addr_i=3.
  - Same cycle: rs1_data_o=0xDEADBEEF.
  - Next cycle: still 0xDEADBEEF from the array, and retired_o=1.
- x0 protection: accept {write=1, addr=0, data=0x1234} and drive dbg write of addr 0 with 0xFFFF.
  - rs2_data_o at rs2_addr_i=0 stays 0.
  - buf_valid is never set; input_ready_o stays 1.
- Collision: in one cycle, dbg write {addr=7, data=0xAAAA} plus an accepted transfer {addr=7, data=0x5555}.
  - Next cycle: input_ready_o=0 and rs1_data_o at addr 7 = 0x5555 (from the buffer).
  - Following cycle: the array holds 0x5555 and input_ready_o=1.
- Held debug: dbg_write_i high for 3 cycles after a collision.
  - The buffer persists for all 3 cycles with input_ready_o=0.
  - Upstream valid is held with new data and no extra transfer is counted.
  - The buffered value drains on the first cycle with dbg_write_i low.
- Counter wrap: RETIRED_WIDTH=4 with 17 accepted transfers (mix of write=0 and write=1) -> retired_o=1.
